rhd_spi_master: RTL
===================

// Module: rhd_spi_master
// PURPOSE
// - Host-side SPI master for the RHD headstage link; drives CS/SCLK/MOSI and captures MISO from rhd_spi_slave.
// - Each frame shifts one 16-bit command out and captures two interleaved 16-bit results: word A (ch 0-31), word B (ch 32-63).
// - Sits between the acquisition sequencer (cmd in) and the sample formatter (rx out).
// PARAMETERS
// - HALF_PERIOD      4  clk cycles per SCLK half-period (SCLK period = 2*HALF_PERIOD); min 2
// - SAMPLE_A_OFFSET  7  clk cycle within SCLK period (0 = first SCLK-high cycle) at which MISO is captured into word A
// - SAMPLE_B_OFFSET  3  clk cycle within SCLK period at which MISO is captured into word B; must differ from A
// - CS_SETUP_CYCLES  2  clk cycles CS low before first SCLK rise
// - CS_HOLD_CYCLES   2  clk cycles after last SCLK fall before CS rises
// - CS_GAP_CYCLES    4  min clk cycles CS high between frames
// PORTS
// - clk        in   1   system clock
// - rstn       in   1   asynchronous active-low reset
// - cmd_valid  in   1   command request
// - cmd_data   in   16  command word, MSB sent first
// - cmd_ready  out  1   high in IDLE only; cmd accepted on cmd_valid & cmd_ready
// - CS         out  1   chip select, active low
// - SCLK       out  1   serial clock, idle low
// - MOSI       out  1   serial data out
// - MISO       in   1   serial data in (same clk domain, no synchroniser)
// - rx_valid   out  1   one-cycle pulse, frame complete
// - rx_data_a  out  16  word A, MSB first captured; held until next rx_valid
// - rx_data_b  out  16  word B, MSB first captured; held until next rx_valid
// - busy       out  1   high in any state except IDLE
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, CS=1, SCLK=0, MOSI=0, rx_valid=0, rx_data_a/b=0, busy=0, cmd_ready=1 after release.
// - FSM: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> CS_GAP -> IDLE.
// - IDLE: on accept, latch cmd_data into shift reg; next cycle CS=0, MOSI=cmd_data[15], enter CS_SETUP.
// - CS_SETUP: CS_SETUP_CYCLES cycles, then SHIFT with phase=0, bit=15.
// - SHIFT: phase counter 0..2*HALF_PERIOD-1; SCLK=1 for phase<HALF_PERIOD else 0.
//   - phase==SAMPLE_A_OFFSET: rx_a_sh[bit] <= MISO; phase==SAMPLE_B_OFFSET: rx_b_sh[bit] <= MISO.
//   - phase==HALF_PERIOD (SCLK falls): MOSI <= next lower command bit (bit 0 holds until CS_HOLD ends).
//   - end of period: bit decrements; after bit 0 period completes -> CS_HOLD.
//   - exactly 16 SCLK rising edges per frame; SCLK low entering/leaving SHIFT.
// - CS_HOLD: CS_HOLD_CYCLES cycles, then CS=1, MOSI=0, rx_data_a/b <= shift regs, rx_valid=1 for that one cycle, enter CS_GAP.
// - CS_GAP: CS_GAP_CYCLES cycles, cmd_ready=0; then IDLE. Back-to-back cmd_valid accepted on first IDLE cycle.
// - Frame length = 1 + CS_SETUP + 32*HALF_PERIOD + CS_HOLD clk cycles from accept to CS rise.
// - cmd_valid/cmd_data changes while busy: ignored. rx_valid never asserted for a frame cut by reset.
// - Counters sized by $clog2 of their max; no wrap other than phase rollover.
// STRUCTURE
// - Package rhd_pkg: state enum, RHD_FRAME_BITS=16, RHD_NUM_STREAMS=2.
// - Sub-module rhd_sclk_timer: phase counter, SCLK, rise/fall/sample-A/sample-B strobes; FSM + shift regs in top.
// TESTING
// - Single frame, cmd 0xA5C3, MISO model A=0x1234 B=0xABCD -> MOSI bits 0xA5C3 at SCLK rises, rx_a=0x1234, rx_b=0xABCD, one rx_valid.
// - Timing check defaults -> exactly 16 SCLK rises, SCLK period 8 clk, CS low 2+128+2+1 cycles, CS high >=4 between frames.
// - Back-to-back: cmd_valid held high, cmds 0x0001,0x8000 -> two frames, gap exactly CS_GAP_CYCLES, results in order.
// - Reset asserted mid-SHIFT (bit 7) -> CS=1, SCLK=0 immediately; no rx_valid; next frame correct.
// - Against rhd_spi_slave channel=5, seed 0 -> rx_a=0x0003, rx_b=0x0023 on frame 1.
// - cmd_data toggled during busy -> transmitted word unchanged.

Source files
------------

// File: rtl/rhd_pkg.sv
// Shared types and constants for the RHD headstage SPI link.
package rhd_pkg;

    localparam int RHD_FRAME_BITS  = 16;
    localparam int RHD_NUM_STREAMS = 2;
    localparam int RHD_BIT_W       = $clog2(RHD_FRAME_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_CS_GAP
    } rhd_state_e;

    function automatic int rhd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rhd_sclk_timer.sv
// SCLK generator: phase counter within one SCLK period plus the strobes the
// frame FSM needs. Phase 0 is the first SCLK-high cycle of a period.
module rhd_sclk_timer #(
    parameter int HALF_PERIOD     = 4,
    parameter int SAMPLE_A_OFFSET = 7,
    parameter int SAMPLE_B_OFFSET = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic start_i,
    input  logic last_i,
    output logic sclk_o,
    output logic fall_o,
    output logic period_end_o,
    output logic sample_a_o,
    output logic sample_b_o
);
    localparam int PERIOD = 2 * HALF_PERIOD;
    localparam int PH_W   = $clog2(PERIOD);

    logic [PH_W-1:0] phase_q;
    logic            active_q;
    logic            sclk_q;
    logic            phase_last;

    assign phase_last = (phase_q == PH_W'(PERIOD - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q  <= '0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
        end else if (start_i) begin
            phase_q  <= '0;
            active_q <= 1'b1;
            sclk_q   <= 1'b1;
        end else if (active_q) begin
            if (phase_last) begin
                phase_q <= '0;
                // Stopping after the final period keeps SCLK low on exit.
                if (last_i) begin
                    active_q <= 1'b0;
                    sclk_q   <= 1'b0;
                end else begin
                    sclk_q   <= 1'b1;
                end
            end else begin
                phase_q <= phase_q + PH_W'(1);
                sclk_q  <= (phase_q < PH_W'(HALF_PERIOD - 1));
            end
        end
    end

    assign sclk_o       = sclk_q;
    assign fall_o       = active_q && (phase_q == PH_W'(HALF_PERIOD));
    assign period_end_o = active_q && phase_last;
    assign sample_a_o   = active_q && (phase_q == PH_W'(SAMPLE_A_OFFSET));
    assign sample_b_o   = active_q && (phase_q == PH_W'(SAMPLE_B_OFFSET));

endmodule

// File: rtl/rhd_spi_master.sv
// Host-side SPI master: sends one 16-bit command per frame and captures two
// interleaved 16-bit result words (A and B) from MISO.
module rhd_spi_master
    import rhd_pkg::*;
#(
    parameter int HALF_PERIOD     = 4,
    parameter int SAMPLE_A_OFFSET = 7,
    parameter int SAMPLE_B_OFFSET = 3,
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2,
    parameter int CS_GAP_CYCLES   = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cmd_valid,
    input  logic [RHD_FRAME_BITS-1:0] cmd_data,
    output logic                      cmd_ready,
    output logic                      CS,
    output logic                      SCLK,
    output logic                      MOSI,
    input  logic                      MISO,
    output logic                      rx_valid,
    output logic [RHD_FRAME_BITS-1:0] rx_data_a,
    output logic [RHD_FRAME_BITS-1:0] rx_data_b,
    output logic                      busy
);
    localparam int CNT_MAX = rhd_max(CS_SETUP_CYCLES, rhd_max(CS_HOLD_CYCLES - 1, CS_GAP_CYCLES - 1));
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    rhd_state_e                state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [RHD_BIT_W-1:0]      bit_q;
    logic [RHD_FRAME_BITS-1:0] cmd_sh_q;
    logic [RHD_FRAME_BITS-1:0] rx_a_sh_q;
    logic [RHD_FRAME_BITS-1:0] rx_b_sh_q;
    logic                      cs_q;
    logic                      mosi_q;
    logic                      rx_valid_q;
    logic [RHD_FRAME_BITS-1:0] rx_a_q;
    logic [RHD_FRAME_BITS-1:0] rx_b_q;

    logic tmr_start, tmr_fall, tmr_period_end, tmr_sample_a, tmr_sample_b;

    // The accept cycle already drives CS low with MSB on MOSI, so setup ends
    // one count later than CS_SETUP_CYCLES-1 to give 1+setup cycles before SCLK.
    assign tmr_start = (state_q == ST_CS_SETUP) && (cnt_q == CNT_W'(CS_SETUP_CYCLES));

    rhd_sclk_timer #(
        .HALF_PERIOD    (HALF_PERIOD),
        .SAMPLE_A_OFFSET(SAMPLE_A_OFFSET),
        .SAMPLE_B_OFFSET(SAMPLE_B_OFFSET)
    ) u_timer (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (tmr_start),
        .last_i      (bit_q == '0),
        .sclk_o      (SCLK),
        .fall_o      (tmr_fall),
        .period_end_o(tmr_period_end),
        .sample_a_o  (tmr_sample_a),
        .sample_b_o  (tmr_sample_b)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            cmd_sh_q   <= '0;
            rx_a_sh_q  <= '0;
            rx_b_sh_q  <= '0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_a_q     <= '0;
            rx_b_q     <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_sh_q <= cmd_data;
                        cs_q     <= 1'b0;
                        mosi_q   <= cmd_data[RHD_FRAME_BITS-1];
                        cnt_q    <= '0;
                        state_q  <= ST_CS_SETUP;
                    end
                end
                ST_CS_SETUP: begin
                    if (tmr_start) begin
                        bit_q   <= RHD_BIT_W'(RHD_FRAME_BITS - 1);
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (tmr_sample_a) rx_a_sh_q[bit_q] <= MISO;
                    if (tmr_sample_b) rx_b_sh_q[bit_q] <= MISO;
                    if (tmr_fall && (bit_q != '0)) mosi_q <= cmd_sh_q[bit_q - RHD_BIT_W'(1)];
                    if (tmr_period_end) begin
                        if (bit_q == '0) begin
                            cnt_q   <= '0;
                            state_q <= ST_CS_HOLD;
                        end else begin
                            bit_q <= bit_q - RHD_BIT_W'(1);
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (cnt_q == CNT_W'(CS_HOLD_CYCLES - 1)) begin
                        cs_q       <= 1'b1;
                        mosi_q     <= 1'b0;
                        rx_a_q     <= rx_a_sh_q;
                        rx_b_q     <= rx_b_sh_q;
                        rx_valid_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_CS_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CS_GAP: begin
                    if (cnt_q == CNT_W'(CS_GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign CS        = cs_q;
    assign MOSI      = mosi_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data_a = rx_a_q;
    assign rx_data_b = rx_b_q;

endmodule
